// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: ALU control decoder with an iterative shift-add multiplier that stalls while busy
module alu_ctrl_mc #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [5:0]       ALU_op_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic [3:0]       ALU_ctrl_o,
   output logic [2:0]       ALU_ex_ctrl_o,
   output logic             mul_sel_o,
   output logic [WIDTH-1:0] mul_result_o,
   output logic             valid_o,
   output logic             stall_o,
   output logic             illegal_o
);
   localparam int N  = WIDTH / BPC;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] mcand, mplier, acc, sum;
   logic [CW-1:0] cnt;
   logic [3:0] dec_ctrl;
   logic [2:0] dec_ex;
   logic accept, is_mul, dec_ill, last, pulse;

   assign ready_o = state != MUL;
   assign stall_o = state == MUL;
   assign valid_o = pulse | (state == DONE);
   assign accept  = valid_i & ready_o;
   assign last    = cnt == CW'(N - 1);
   // one partial product per cycle: the low BPC multiplier bits times the shifted multiplicand
   assign sum     = acc + mcand * WIDTH'(mplier[BPC-1:0]);

   // opcode/funct decode into control codes, flagging MUL and undecoded encodings
   always_comb begin
      dec_ctrl = 4'b0000;
      dec_ex   = 3'b000;
      dec_ill  = 1'b0;
      is_mul   = 1'b0;
      case (ALU_op_i)
         6'b000000:
            case (funct_i)
               6'b100000: dec_ctrl = 4'b0010;
               6'b100010: dec_ctrl = 4'b0110;
               6'b100100: dec_ctrl = 4'b0000;
               6'b100101: dec_ctrl = 4'b0001;
               6'b101010: dec_ctrl = 4'b0111;
               6'b011000: begin
                  dec_ctrl = 4'b0011;
                  is_mul   = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         6'b001000, 6'b100011, 6'b101011: dec_ctrl = 4'b0010;
         6'b000100: {dec_ctrl, dec_ex} = {4'b0111, 3'b110};
         6'b000111: {dec_ctrl, dec_ex} = {4'b0111, 3'b001};
         6'b000101: {dec_ctrl, dec_ex} = {4'b0111, 3'b100};
         6'b000001: {dec_ctrl, dec_ex} = {4'b0111, 3'b011};
         default: dec_ill = 1'b1;
      endcase
   end

   // next state: DONE behaves like IDLE for accepts, so back-to-back MULs lose no cycle
   always_comb begin
      state_nx = state;
      state_nx = (state == MUL) ? (last ? DONE : MUL) : (accept && is_mul) ? MUL : IDLE;
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else state <= state_nx;
   end

   // decode registers and multiplier datapath
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ALU_ctrl_o    <= '0;
         ALU_ex_ctrl_o <= '0;
         mul_sel_o     <= 1'b0;
         mul_result_o  <= '0;
         pulse         <= 1'b0;
         illegal_o     <= 1'b0;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         cnt           <= '0;
      end else begin
         pulse     <= accept & ~is_mul;
         illegal_o <= accept & dec_ill;
         if (accept) begin
            ALU_ctrl_o    <= dec_ctrl;
            ALU_ex_ctrl_o <= dec_ex;
            mul_sel_o     <= is_mul;
         end
         if (accept && is_mul) begin
            mcand  <= src1_i;
            mplier <= src2_i;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == MUL) begin
            acc    <= sum;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt + CW'(1);
            if (last) mul_result_o <= sum;
         end
      end
   end
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb_alu_ctrl_mc: directed and randomized checks of decode and multiply timing on BPC=1 and BPC=4 instances
module tb_alu_ctrl_mc;
   logic clk = 1'b0, rst_n = 1'b0, v1 = 1'b0, v4 = 1'b0;
   logic [5:0] op = '0, funct = '0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] r1, r4;
   logic [3:0] c1, c4;
   logic [2:0] e1, e4;
   logic rd1, rd4, va1, va4, st1, st4, il1, il4, ms1, ms4;
   logic [11:0] o1, o4;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   alu_ctrl_mc #(.WIDTH(32), .BPC(1)) u1 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(v1), .ready_o(rd1), .ALU_op_i(op), .funct_i(funct),
      .src1_i(a), .src2_i(b), .ALU_ctrl_o(c1), .ALU_ex_ctrl_o(e1), .mul_sel_o(ms1),
      .mul_result_o(r1), .valid_o(va1), .stall_o(st1), .illegal_o(il1));
   alu_ctrl_mc #(.WIDTH(32), .BPC(4)) u4 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(v4), .ready_o(rd4), .ALU_op_i(op), .funct_i(funct),
      .src1_i(a), .src2_i(b), .ALU_ctrl_o(c4), .ALU_ex_ctrl_o(e4), .mul_sel_o(ms4),
      .mul_result_o(r4), .valid_o(va4), .stall_o(st4), .illegal_o(il4));

   // observed bundle: {ready, valid, stall, illegal, mul_sel, ctrl[3:0], ex[2:0]}
   assign o1 = {rd1, va1, st1, il1, ms1, c1, e1};
   assign o4 = {rd4, va4, st4, il4, ms4, c4, e4};

   // reference decode table: {illegal, ctrl[3:0], ex[2:0]}
   function automatic logic [7:0] ref_dec(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'b000000) begin
         if (f == 6'b100000) return {1'b0, 4'b0010, 3'b000};
         if (f == 6'b100010) return {1'b0, 4'b0110, 3'b000};
         if (f == 6'b100100) return {1'b0, 4'b0000, 3'b000};
         if (f == 6'b100101) return {1'b0, 4'b0001, 3'b000};
         if (f == 6'b101010) return {1'b0, 4'b0111, 3'b000};
         return {1'b1, 7'b0};
      end
      if (o == 6'b001000 || o == 6'b100011 || o == 6'b101011) return {1'b0, 4'b0010, 3'b000};
      if (o == 6'b000100) return {1'b0, 4'b0111, 3'b110};
      if (o == 6'b000111) return {1'b0, 4'b0111, 3'b001};
      if (o == 6'b000101) return {1'b0, 4'b0111, 3'b100};
      if (o == 6'b000001) return {1'b0, 4'b0111, 3'b011};
      return {1'b1, 7'b0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one instruction at a negedge, let it be accepted, return at the following negedge
   task automatic issue(input bit s, input logic [5:0] o, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      op = o; funct = f; a = x; b = y;
      if (s) v4 = 1'b1; else v1 = 1'b1;
      chk("ready_at_issue", s ? rd4 : rd1, 1);
      @(posedge clk);
      #1 v1 = 1'b0; v4 = 1'b0;
      @(negedge clk);
   endtask

   task automatic alu_op(input bit s, input logic [5:0] o, input logic [5:0] f, input string tag);
      logic [7:0] e;
      e = ref_dec(o, f);
      issue(s, o, f, $urandom, $urandom);
      chk(tag, s ? o4 : o1, {1'b1, 1'b1, 1'b0, e[7], 1'b0, e[6:0]});
   endtask

   // multiply: expect N stalled cycles, then one DONE cycle carrying the truncated product
   task automatic mul_op(input bit s, input logic [31:0] x, input logic [31:0] y, input bit hold, input string tag);
      int stalls = 0;
      bit done = 0;
      logic [31:0] p;
      p = x * y;
      issue(s, 6'b000000, 6'b011000, x, y);
      chk({tag, "_first"}, s ? o4 : o1, {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 3'b000});
      if (hold) begin
         op = 6'b000000; funct = 6'b100000;
         if (s) v4 = 1'b1; else v1 = 1'b1;
      end
      for (int i = 0; i < 200 && !done; i++) begin
         if (s ? va4 : va1) done = 1;
         else begin
            stalls++;
            @(negedge clk);
         end
      end
      v1 = 1'b0; v4 = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_stalls"}, stalls, s ? 8 : 32);
      chk({tag, "_result"}, s ? r4 : r1, p);
      chk({tag, "_outs"}, s ? o4 : o1, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 3'b000});
   endtask

   initial begin
      int pulses;
      logic [5:0] ops [15];
      logic [5:0] fns [15];
      ops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b001000, 6'b100011, 6'b101011,
              6'b000100, 6'b000111, 6'b000101, 6'b000001, 6'b111111, 6'd0};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'd0, 6'd0, 6'd0,
              6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b111110};
      repeat (3) @(negedge clk);
      chk("reset_u1", o1, 12'h800);
      chk("reset_u4", o4, 12'h800);
      chk("reset_res", r1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // reset in the middle of a multiply discards it
      issue(0, 6'b000000, 6'b011000, 32'd7, -32'sd3);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midmul_reset_outs", o1, 12'h800);
      chk("midmul_reset_res", r1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (va1) pulses++;
      end
      chk("midmul_no_valid", pulses, 0);

      // directed decode
      alu_op(0, 6'b000000, 6'b100000, "add");
      alu_op(0, 6'b000000, 6'b100010, "sub");
      alu_op(0, 6'b000000, 6'b101010, "slt");
      alu_op(0, 6'b000100, 6'b000000, "beq");
      alu_op(0, 6'b000111, 6'b000000, "bgt");
      alu_op(0, 6'b000101, 6'b000000, "bnez");
      alu_op(0, 6'b000001, 6'b000000, "bgez");
      alu_op(0, 6'b111111, 6'b000000, "illegal_op");
      alu_op(0, 6'b000000, 6'b000011, "illegal_funct");
      @(negedge clk);
      chk("pulse_single", {va1, il1}, 2'b00);

      // multiplies
      mul_op(0, 32'd7, -32'sd3, 0, "mul7x-3");
      mul_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "mul4_ff");
      @(negedge clk);
      chk("held_valid_ignored", o4, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 3'b000});
      alu_op(1, 6'b001000, 6'b000000, "addi_u4");
      chk("result_held", r4, 32'h00000001);

      // back-to-back: MUL accepted in DONE, then ADDI accepted in DONE
      mul_op(0, 32'd5, 32'd6, 0, "b2b_mul1");
      mul_op(0, 32'h12345678, 32'h9abcdef0, 0, "b2b_mul2");
      alu_op(0, 6'b001000, 6'b000000, "b2b_addi");

      // randomized mix against the reference model
      for (int i = 0; i < 24; i++) begin
         int k;
         bit s;
         logic [5:0] o, f;
         k = $urandom_range(0, 17);
         s = 1'($urandom_range(0, 1));
         o = (k < 15) ? ops[k] : 6'($urandom);
         f = (k < 15) ? fns[k] : 6'($urandom);
         if (o == 6'b000000 && f == 6'b011000) mul_op(s, $urandom, $urandom, 1'($urandom_range(0, 1)), "rnd_mul");
         else alu_op(s, o, f, "rnd_dec");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
